// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone request always wins, and on a
// conflict the port that was not granted last time wins.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] grant
);

  // last = 1 means port 1 was granted most recently, so port 0 is favoured
  assign grant[0] = req[0] & (~req[1] | last);
  assign grant[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/ram_arbiter.sv
// Serialises CPU (port 0) and loader (port 1) accesses onto one
// synchronous-read RAM. One access at a time: IDLE -> ACCESS -> (RESP) -> IDLE.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  state_t                  state;
  logic                    last;      // id of the most recently granted port
  logic                    owner;     // id of the port owning the current access
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    ram_we_q;
  logic [NUM_PORTS-1:0]    ack_q;
  logic [NUM_PORTS-1:0]    rvalid_q;

  logic [NUM_PORTS-1:0]    req;
  logic [NUM_PORTS-1:0]    grant;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign req       = {req1, req0};
  assign sel_we    = grant[1] ? we1    : we0;
  assign sel_addr  = grant[1] ? addr1  : addr0;
  assign sel_wdata = grant[1] ? wdata1 : wdata0;

  rr_arbiter2 u_rr (
    .req   (req),
    .last  (last),
    .grant (grant)
  );

  // Access sequencer; ack/rvalid/ram_we are registered one-cycle pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ram_we_q <= 1'b0;
      ack_q    <= '0;
      rvalid_q <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      ram_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            owner    <= grant[1];
            last     <= grant[1];
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            ram_we_q <= sel_we;
            ack_q    <= grant;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // the RAM registers its read data on this edge; present it in RESP
          if (we_q) begin
            state <= IDLE;
          end else begin
            rvalid_q[owner] <= 1'b1;
            state           <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset overrides the pulses combinationally so an in-flight access is
  // dropped at once and a pending write never reaches the RAM.
  assign ack0           = ack_q[0] & reset_n;
  assign ack1           = ack_q[1] & reset_n;
  assign rvalid0        = rvalid_q[0] & reset_n;
  assign rvalid1        = rvalid_q[1] & reset_n;
  assign ram_we         = ram_we_q & reset_n;
  assign ram_read_addr  = reset_n ? addr_q  : '0;
  assign ram_write_addr = reset_n ? addr_q  : '0;
  assign ram_data       = reset_n ? wdata_q : '0;
  assign rdata          = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model with a synchronous-read RAM alongside.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [5:0]  ram_read_addr, ram_write_addr;
  logic [31:0] ram_data;
  logic        ram_we;
  logic [31:0] ram_q;

  logic [31:0] mem [64];
  logic        load_ram;
  logic [31:0] ref_mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ram_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_read_addr(ram_read_addr), .ram_write_addr(ram_write_addr),
    .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  // synchronous-read RAM, preloaded with mem[i] = i
  always @(posedge clock) begin
    if (load_ram) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (ram_we) begin
      mem[ram_write_addr] <= ram_data;
    end
    ram_q <= mem[ram_read_addr];
  end

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [5:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_port(0, 1'b1, 1'b1, 6'd9, 32'h1234);
    set_port(1, 1'b1, 1'b0, 6'd4, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_pulses: got %b want 0000", {ack0, ack1, rvalid0, rvalid1}); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++;
      $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_tests++; if ({ram_read_addr, ram_write_addr} !== 12'h000 || ram_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_ram_bus: raddr %0d waddr %0d data %h want 0", ram_read_addr, ram_write_addr, ram_data); end
    n_tests++; if (rdata !== ram_q) begin n_fail++;
      $display("FAIL reset_rdata: got %h want ram_q %h", rdata, ram_q); end
    @(posedge clock); #1;
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    reset_n = 1'b1;
  endtask

  task automatic test_read_port0;
    @(posedge clock); #1 set_port(0, 1'b1, 1'b0, 6'd2, 32'h0);
    @(posedge clock); @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b1000) begin n_fail++;
      $display("FAIL read0_ack: got %b want 1000", {ack0, ack1, rvalid0, rvalid1}); end
    @(posedge clock); #1 set_port(0, 0, 0, 0, 0);
    @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0010) begin n_fail++;
      $display("FAIL read0_rvalid: got %b want 0010", {ack0, ack1, rvalid0, rvalid1}); end
    n_tests++; if (rdata !== ref_mem[2]) begin n_fail++;
      $display("FAIL read0_data: got %h want %h", rdata, ref_mem[2]); end
  endtask

  task automatic test_write_read_port1;
    @(posedge clock); #1 set_port(1, 1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
    @(posedge clock); @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0100 || ram_we !== 1'b1) begin n_fail++;
      $display("FAIL wr1_ack: got %b we %b want 0100 we 1", {ack0, ack1, rvalid0, rvalid1}, ram_we); end
    n_tests++; if (ram_write_addr !== 6'd5 || ram_data !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL wr1_bus: waddr %0d data %h want 5 deadbeef", ram_write_addr, ram_data); end
    ref_mem[5] = 32'hDEADBEEF;
    @(posedge clock); #1 set_port(1, 1'b1, 1'b0, 6'd5, 32'h0);
    @(negedge clock);
    n_tests++; if (ram_we !== 1'b0 || ack1 !== 1'b0) begin n_fail++;
      $display("FAIL wr1_idle: we %b ack1 %b want 0 0", ram_we, ack1); end
    @(posedge clock); @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0100 || ram_we !== 1'b0 || ram_read_addr !== 6'd5) begin n_fail++;
      $display("FAIL rd1_ack: got %b we %b raddr %0d want 0100 0 5", {ack0, ack1, rvalid0, rvalid1}, ram_we, ram_read_addr); end
    @(posedge clock); #1 set_port(1, 0, 0, 0, 0);
    @(negedge clock);
    n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0001 || rdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL rd1_data: got %b %h want 0001 deadbeef", {ack0, ack1, rvalid0, rvalid1}, rdata); end
  endtask

  task automatic test_conflict;
    int g_port[8];
    int g_n, r_n, both;
    logic [31:0] r_data[8];
    int r_port[8];
    g_n = 0; r_n = 0; both = 0;
    @(posedge clock); #1 reset_n = 1'b0;
    set_port(0, 1'b1, 1'b0, 6'd0, 32'h0);
    set_port(1, 1'b1, 1'b0, 6'd1, 32'h0);
    @(posedge clock); #1 reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (ack0 && ack1) both++;
      if ((ack0 || ack1) && g_n < 8) begin g_port[g_n] = ack1 ? 1 : 0; g_n++; end
      if ((rvalid0 || rvalid1) && r_n < 8) begin
        r_port[r_n] = rvalid1 ? 1 : 0; r_data[r_n] = rdata; r_n++;
      end
    end
    @(posedge clock); #1 set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    n_tests++; if (both != 0) begin n_fail++;
      $display("FAIL conflict_both_ack: %0d cycles with both acks, want 0", both); end
    n_tests++; if (g_n != 4 || r_n != 4) begin n_fail++;
      $display("FAIL conflict_count: grants %0d reads %0d want 4 4", g_n, r_n); end
    for (int i = 0; i < 4 && i < g_n && i < r_n; i++) begin
      n_tests++; if (g_port[i] != (i % 2) || r_port[i] != (i % 2) || r_data[i] !== ref_mem[i % 2]) begin n_fail++;
        $display("FAIL conflict_order[%0d]: grant %0d rv %0d data %h want %0d %0d %h",
                 i, g_port[i], r_port[i], r_data[i], i % 2, i % 2, ref_mem[i % 2]); end
    end
    @(posedge clock); @(posedge clock);
  endtask

  task automatic test_single_requester;
    int cyc[4];
    int n, a0;
    n = 0; a0 = 0;
    @(posedge clock); #1 set_port(1, 1'b1, 1'b1, 6'd10, 32'hA5A50001);
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clock);
      if (ack0) a0++;
      if (ack1) begin cyc[n] = c; n++; end
    end
    @(posedge clock); #1 set_port(1, 0, 0, 0, 0);
    ref_mem[10] = 32'hA5A50001;
    n_tests++; if (n != 4 || a0 != 0) begin n_fail++;
      $display("FAIL single_count: ack1 %0d ack0 %0d want 4 0", n, a0); end
    for (int i = 1; i < n; i++) begin
      n_tests++; if (cyc[i] - cyc[i-1] != 2) begin n_fail++;
        $display("FAIL single_spacing[%0d]: got %0d want 2", i, cyc[i] - cyc[i-1]); end
    end
    @(posedge clock);
  endtask

  task automatic test_reset_mid_read;
    int seen;
    seen = 0;
    @(posedge clock); #1 set_port(0, 1'b1, 1'b0, 6'd2, 32'h0);
    @(posedge clock);
    @(posedge clock); #1 reset_n = 1'b0; set_port(0, 0, 0, 0, 0);
    @(negedge clock);
    n_tests++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin n_fail++;
      $display("FAIL rstrd_rvalid: got %b%b want 00", rvalid0, rvalid1); end
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (ack0 || ack1 || rvalid0 || rvalid1) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++;
      $display("FAIL rstrd_quiet: %0d cycles with pulses want 0", seen); end
    @(posedge clock); #1 set_port(0, 1'b1, 1'b0, 6'd7, 32'h0);
    @(posedge clock); @(negedge clock);
    n_tests++; if (ack0 !== 1'b1) begin n_fail++;
      $display("FAIL rstrd_next_ack: got %b want 1", ack0); end
    @(posedge clock); #1 set_port(0, 0, 0, 0, 0);
    @(negedge clock);
    n_tests++; if (rvalid0 !== 1'b1 || rdata !== ref_mem[7]) begin n_fail++;
      $display("FAIL rstrd_next_data: rv %b data %h want 1 %h", rvalid0, rdata, ref_mem[7]); end
  endtask

  task automatic test_reset_mid_write;
    @(posedge clock); #1 set_port(0, 1'b1, 1'b1, 6'd3, 32'h55);
    @(posedge clock); #1 reset_n = 1'b0;
    @(negedge clock);
    n_tests++; if (ram_we !== 1'b0 || ack0 !== 1'b0) begin n_fail++;
      $display("FAIL rstwr_we: we %b ack0 %b want 0 0", ram_we, ack0); end
    @(posedge clock); #1 reset_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 6'd3, 32'h0);
    @(posedge clock); @(negedge clock);
    n_tests++; if (ack0 !== 1'b1) begin n_fail++;
      $display("FAIL rstwr_read_ack: got %b want 1", ack0); end
    @(posedge clock); #1 set_port(0, 0, 0, 0, 0);
    @(negedge clock);
    n_tests++; if (rvalid0 !== 1'b1 || rdata !== ref_mem[3]) begin n_fail++;
      $display("FAIL rstwr_keep: rv %b data %h want 1 %h", rvalid0, rdata, ref_mem[3]); end
  endtask

  // Transaction model: an access takes 2 cycles (write) or 3 (read) from
  // grant to next grant; conflicts go to the port not served last.
  task automatic test_random;
    int          st[2], cnt[2], busy, w;
    logic        p_we[2];
    logic [5:0]  p_addr[2];
    logic [31:0] p_data[2];
    logic        last_m;
    logic [1:0]  e0_ack, e0_rv, e1_rv, elig;
    logic        e0_we;
    logic [5:0]  e0_addr;
    logic [31:0] e0_data, e0_rdata, e1_data;
    for (int p = 0; p < 2; p++) begin st[p] = 0; cnt[p] = 0; end
    busy = 0; last_m = 1'b1;
    e0_ack = '0; e0_rv = '0; e1_rv = '0; e0_we = 1'b0;
    e0_addr = '0; e0_data = '0; e0_rdata = '0; e1_data = '0;
    @(posedge clock); #1 reset_n = 1'b0;
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      n_tests++; if ({ack0, ack1, rvalid0, rvalid1} !== {e0_ack[0], e0_ack[1], e0_rv[0], e0_rv[1]}) begin n_fail++;
        $display("FAIL rand_pulses@%0d: got %b want %b", k, {ack0, ack1, rvalid0, rvalid1},
                 {e0_ack[0], e0_ack[1], e0_rv[0], e0_rv[1]}); end
      n_tests++; if (ram_we !== (e0_ack != 0 && e0_we)) begin n_fail++;
        $display("FAIL rand_we@%0d: got %b want %b", k, ram_we, (e0_ack != 0 && e0_we)); end
      if (e0_ack != 0) begin
        n_tests++; if (ram_read_addr !== e0_addr || ram_write_addr !== e0_addr) begin n_fail++;
          $display("FAIL rand_addr@%0d: r %0d w %0d want %0d", k, ram_read_addr, ram_write_addr, e0_addr); end
        if (e0_we) begin
          n_tests++; if (ram_data !== e0_data) begin n_fail++;
            $display("FAIL rand_wdata@%0d: got %h want %h", k, ram_data, e0_data); end
        end
      end
      if (e0_rv != 0) begin
        n_tests++; if (rdata !== e0_rdata) begin n_fail++;
          $display("FAIL rand_rdata@%0d: got %h want %h", k, rdata, e0_rdata); end
      end
      e0_rv = e1_rv; e0_rdata = e1_data; e1_rv = '0; e0_ack = '0; e0_we = 1'b0;
      elig = {st[1] == 1, st[0] == 1};
      if (busy > 0) begin
        busy--;
      end else if (elig != 0) begin
        w = (elig == 2'b11) ? (last_m ? 0 : 1) : (elig[1] ? 1 : 0);
        last_m = (w == 1);
        e0_ack[w] = 1'b1; e0_we = p_we[w]; e0_addr = p_addr[w]; e0_data = p_data[w];
        if (p_we[w]) begin
          ref_mem[p_addr[w]] = p_data[w]; busy = 1;
        end else begin
          e1_rv[w] = 1'b1; e1_data = ref_mem[p_addr[w]]; busy = 2;
        end
        st[w] = 2; cnt[w] = 2;
      end
      @(posedge clock); #1;
      for (int p = 0; p < 2; p++) begin
        if (st[p] == 2) begin
          cnt[p]--;
          if (cnt[p] == 0) begin st[p] = 0; set_port(p, 0, 0, 0, 0); end
        end
        if (st[p] == 0 && $urandom_range(2) == 0) begin
          st[p] = 1;
          p_we[p] = 1'($urandom_range(1));
          p_addr[p] = 6'($urandom_range(15));
          p_data[p] = $urandom;
          set_port(p, 1'b1, p_we[p], p_addr[p], p_data[p]);
        end
      end
    end
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i);
    reset_n = 1'b0; load_ram = 1'b1;
    set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
    @(posedge clock); #1 load_ram = 1'b0;
    test_reset();
    test_read_port0();
    test_write_read_port1();
    test_conflict();
    test_single_requester();
    test_reset_mid_read();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: word width, equal to the RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: word address width, equal to the RAM address width.
REQ-003 SHALL have port clock, input, 1: single clock, shared with the RAM it drives.
REQ-004 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1: access request from port 0 (CPU) / port 1 (I/O loader).
REQ-006 SHALL have ports we0/we1, input, 1: 1 = write, 0 = read, qualified by reqN.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_WIDTH: word address, qualified by reqN.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_WIDTH: write data, qualified by reqN & weN.
REQ-009 SHALL have ports ack0/ack1, output, 1: one-cycle pulse, request accepted.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1: one-cycle pulse, rdata holds read result.
REQ-011 SHALL have port rdata, output, DATA_WIDTH: read data shared by both ports, valid only with rvalidN.
REQ-012 SHALL have ports ram_read_addr / ram_write_addr, output, ADDR_WIDTH: driven to the RAM address inputs.
REQ-013 SHALL have ports ram_data (output, DATA_WIDTH), ram_we (output, 1), ram_q (input, DATA_WIDTH): RAM write data, write enable, read data.

Function
REQ-014 SHALL implement states IDLE, ACCESS, RESP.
REQ-015 In IDLE, with any reqN high at a clock edge, SHALL register the winner's we, addr and wdata and the winner id, and go to ACCESS.
REQ-016 With both requests high in IDLE, SHALL grant the port not granted last (round-robin); after reset port 0 wins the first conflict.
REQ-017 With a single request, SHALL grant it regardless of round-robin pointer; the pointer updates to the granted port on every grant.
REQ-018 In ACCESS, SHALL drive ram_read_addr = ram_write_addr = registered addr, ram_data = registered wdata, ram_we = registered we; SHALL assert ackN of the winner for exactly this cycle.
REQ-019 Outside ACCESS, SHALL hold ram_we = 0; address and data outputs hold their last value.
REQ-020 ACCESS SHALL go to IDLE for a write and to RESP for a read.
REQ-021 In RESP, SHALL drive rdata = ram_q and pulse rvalidN of the read's owner for one cycle, then go to IDLE.
REQ-022 Latency from request sampled (edge E) SHALL be: ack in cycle E+1; for a read, rvalid in cycle E+2; next grant at edge E+2 (write) or E+3 (read).
REQ-023 Requests SHALL be ignored outside IDLE; a requester holds reqN and its qualifiers stable until ackN; reqN still high in the cycle after ackN counts as a new request.
REQ-024 Accesses SHALL be serialized, so a read following a write to the same address returns the new data.
REQ-025 ack0/ack1 SHALL never be high together; rvalid0/rvalid1 likewise.

Reset
REQ-026 While reset_n is low at a clock edge, SHALL go to IDLE with the round-robin pointer set to port 1 (port 0 favoured) and clear all registered request fields.
REQ-027 During reset, SHALL drive ack0/1 = 0, rvalid0/1 = 0, ram_we = 0, ram_read_addr = ram_write_addr = 0, ram_data = 0 and rdata = ram_q.
REQ-028 Reset in ACCESS or RESP SHALL abort the access with no ack or rvalid afterwards; a write in ACCESS on the reset edge is not performed, since ram_we is forced to 0 combinationally while reset_n is low.

Structure
REQ-029 State encoding (IDLE/ACCESS/RESP) and the port-count constant (2) SHALL reside in the shared package ram_arbiter_pkg.
REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter2: inputs req[1:0] and last pointer; output one-hot grant.
REQ-031 The block SHALL contain no storage array; the RAM remains a separate instance wired to ram_*.

Verification
REQ-032 Read port 0: RAM preloaded with word 2 = 2; req0 = 1, we0 = 0, addr0 = 2 at edge E -> ack0 in E+1, rvalid0 = 1 with rdata = 2 in E+2, rvalid1 = 0 throughout.
REQ-033 Write then read port 1: write addr 5 = 0xDEADBEEF, then read addr 5 -> ram_we = 1 only in the write's ACCESS cycle; rvalid1 with rdata = 0xDEADBEEF.
REQ-034 Conflict: req0 and req1 both held high from reset release, reads of addr 0 and addr 1 -> grant order 0, 1, 0, 1; rdata alternates 0, 1; no simultaneous ack.
REQ-035 Single requester: req1 held high for four consecutive write transactions -> four ack1 pulses, two cycles apart, port 0 never acked.
REQ-036 Reset mid-read: reset_n low during RESP of a port-0 read -> no rvalid0; state IDLE; the next read completes normally.
REQ-037 Reset mid-write: reset_n low during ACCESS of a write of 0x55 to addr 3 -> ram_we = 0 and addr 3 keeps its old value.
